// File: rtl/sync_bus_pkg.sv
// Default timing constants and shared types for the sync bus generator.
package sync_bus_pkg;

  localparam int unsigned CNT_W      = 9;
  localparam int unsigned PH_W       = 8;
  localparam int unsigned MAX_LAYERS = 8;

  localparam int unsigned H_START    = 128;
  localparam int unsigned H_LAST     = 511;
  localparam int unsigned HS_START   = 160;
  localparam int unsigned HS_END     = 192;
  localparam int unsigned VINC_H     = 368;
  localparam int unsigned V_START    = 248;
  localparam int unsigned V_LAST     = 511;
  localparam int unsigned VBL_START  = 480;
  localparam int unsigned VBL_END    = 272;

  typedef logic [2:0] fine_scroll_t;

  // True when line v falls inside the vertical blank window (window may wrap).
  function automatic logic in_vbl_window(input logic [CNT_W-1:0] v,
                                         input logic [CNT_W-1:0] vs,
                                         input logic [CNT_W-1:0] ve);
    if (vs > ve) return (v >= vs) || (v < ve);
    return (v >= vs) && (v < ve);
  endfunction

endpackage

// File: rtl/sync_bus_gen_if.sv
// Sync bus between the timing generator (master) and its consumers (slave).
interface sync_bus_gen_if
  import sync_bus_pkg::*;
#(
  parameter int unsigned N_LAYERS = 3
) ();

  logic                CE_PIX;
  logic                HINV;
  logic                VINV;
  logic [7:0]          Z80A_DATABUS;
  logic [N_LAYERS-1:0] SPH;

  logic [CNT_W-1:0]    SB_HN;
  logic [7:0]          SB_H;
  logic [7:0]          SB_V;
  logic [PH_W-1:0]     PH;
  logic                HSYNC;
  logic                VSYNC;
  logic                HBL;
  logic                VBL;
  logic                BLANK;
  logic [N_LAYERS-1:0] SNLD;
  logic                VBL_IRQ;
  logic                FRAME_START;

  modport master (
    input  CE_PIX, HINV, VINV, Z80A_DATABUS, SPH,
    output SB_HN, SB_H, SB_V, PH, HSYNC, VSYNC, HBL, VBL, BLANK, SNLD,
           VBL_IRQ, FRAME_START
  );

  modport slave (
    output CE_PIX, HINV, VINV, Z80A_DATABUS, SPH,
    input  SB_HN, SB_H, SB_V, PH, HSYNC, VSYNC, HBL, VBL, BLANK, SNLD,
           VBL_IRQ, FRAME_START
  );

endinterface

// File: rtl/sync_bus_scroll_latch.sv
// One fine-scroll channel: SPH rising-edge latch of CPU data and HPIX compare.
module sync_bus_scroll_latch
  import sync_bus_pkg::*;
(
  input  logic         clkm_48MHZ,
  input  logic         RESET,
  input  logic         sph,
  input  fine_scroll_t data,
  input  fine_scroll_t hpix_lo,
  output logic         snld
);

  logic         sph_q;
  logic         armed;
  fine_scroll_t dh;

  // armed only after SPH has been seen low, so a strobe held through reset cannot latch
  always_ff @(posedge clkm_48MHZ or posedge RESET) begin
    if (RESET) begin
      sph_q <= 1'b0;
      armed <= 1'b0;
      dh    <= '0;
    end else begin
      sph_q <= sph;
      if (!sph) armed <= 1'b1;
      if (sph && !sph_q && armed) dh <= data;
    end
  end

  assign snld = (dh != hpix_lo);

endmodule

// File: rtl/sync_bus_gen.sv
// Parametrised video timing generator: H/V counters, sync, blanking, PH and fine-scroll strobes.
module sync_bus_gen #(
  parameter int unsigned H_START   = sync_bus_pkg::H_START,
  parameter int unsigned H_LAST    = sync_bus_pkg::H_LAST,
  parameter int unsigned HS_START  = sync_bus_pkg::HS_START,
  parameter int unsigned HS_END    = sync_bus_pkg::HS_END,
  parameter int unsigned VINC_H    = sync_bus_pkg::VINC_H,
  parameter int unsigned V_START   = sync_bus_pkg::V_START,
  parameter int unsigned V_LAST    = sync_bus_pkg::V_LAST,
  parameter int unsigned VBL_START = sync_bus_pkg::VBL_START,
  parameter int unsigned VBL_END   = sync_bus_pkg::VBL_END,
  parameter int unsigned N_LAYERS  = 3
) (
  input  logic           clkm_48MHZ,
  input  logic           RESET,
  sync_bus_gen_if.master bus
);

  import sync_bus_pkg::*;

  if (H_START > H_LAST || V_START > V_LAST || HS_END < HS_START ||
      N_LAYERS == 0 || N_LAYERS > MAX_LAYERS) begin : g_param_err
    $error("sync_bus_gen: illegal timing or layer parameters");
  end

  localparam logic [CNT_W-1:0] H_START_C   = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] H_LAST_C    = CNT_W'(H_LAST);
  localparam logic [CNT_W-1:0] HS_START_C  = CNT_W'(HS_START);
  localparam logic [CNT_W-1:0] HS_END_C    = CNT_W'(HS_END);
  localparam logic [CNT_W-1:0] VINC_H_C    = CNT_W'(VINC_H);
  localparam logic [CNT_W-1:0] V_START_C   = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] V_LAST_C    = CNT_W'(V_LAST);
  localparam logic [CNT_W-1:0] VBL_START_C = CNT_W'(VBL_START);
  localparam logic [CNT_W-1:0] VBL_END_C   = CNT_W'(VBL_END);
  localparam logic             VBL_RST     = in_vbl_window(V_START_C, VBL_START_C, VBL_END_C);

  logic [CNT_W-1:0]    hpix;
  logic [CNT_W-1:0]    vpix;
  logic [CNT_W-1:0]    hpix_nxt;
  logic [CNT_W-1:0]    vpix_nxt;
  logic                vinc;
  logic [PH_W-1:0]     ph;
  logic                vbl;
  logic                vbl_d;
  logic                vbl_irq;
  logic                frame_pend;
  logic                frame_start;
  logic [N_LAYERS-1:0] snld;
  logic                unused_data_hi;

  // Next counter values; vinc marks the pixel step on which the line count moves
  always_comb begin
    hpix_nxt = hpix;
    vpix_nxt = vpix;
    vinc     = 1'b0;
    if (bus.CE_PIX) begin
      hpix_nxt = (hpix == H_LAST_C) ? H_START_C : hpix + CNT_W'(1);
      if (hpix == VINC_H_C) begin
        vinc     = 1'b1;
        vpix_nxt = (vpix == V_LAST_C) ? V_START_C : vpix + CNT_W'(1);
      end
    end
  end

  // Pulses are generated from state that keeps running while CE_PIX is low
  always_ff @(posedge clkm_48MHZ or posedge RESET) begin
    if (RESET) begin
      hpix        <= H_START_C;
      vpix        <= V_START_C;
      ph          <= '0;
      vbl         <= VBL_RST;
      vbl_d       <= VBL_RST;
      vbl_irq     <= 1'b0;
      frame_pend  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hpix <= hpix_nxt;
      vpix <= vpix_nxt;
      if (bus.CE_PIX) ph <= {ph[PH_W-2:0], ~(hpix[2] & hpix[1])};
      if (vinc) begin
        if (vpix_nxt == VBL_START_C)    vbl <= 1'b1;
        else if (vpix_nxt == VBL_END_C) vbl <= 1'b0;
      end
      vbl_d       <= vbl;
      vbl_irq     <= vbl & ~vbl_d;
      frame_pend  <= vinc && (vpix == V_LAST_C);
      frame_start <= frame_pend;
    end
  end

  for (genvar i = 0; i < int'(N_LAYERS); i++) begin : g_layer
    sync_bus_scroll_latch u_latch (
      .clkm_48MHZ (clkm_48MHZ),
      .RESET      (RESET),
      .sph        (bus.SPH[i]),
      .data       (fine_scroll_t'(bus.Z80A_DATABUS[2:0])),
      .hpix_lo    (fine_scroll_t'(hpix[2:0])),
      .snld       (snld[i])
    );
  end

  assign unused_data_hi = ^bus.Z80A_DATABUS[7:3];

  assign bus.SB_HN       = hpix;
  assign bus.SB_H        = hpix[7:0] ^ {8{bus.HINV}};
  assign bus.SB_V        = vpix[7:0] ^ {8{bus.VINV}};
  assign bus.PH          = ph;
  assign bus.HSYNC       = (hpix >= HS_START_C) && (hpix <= HS_END_C);
  assign bus.HBL         = ~hpix[8];
  assign bus.VSYNC       = vpix[8];
  assign bus.VBL         = vbl;
  assign bus.BLANK       = ~hpix[8] | vbl;
  assign bus.SNLD        = snld;
  assign bus.VBL_IRQ     = vbl_irq;
  assign bus.FRAME_START = frame_start;

endmodule

// File: tb/tb_sync_bus_gen.sv
// Directed bench for sync_bus_gen: default-timing instance plus a short-frame instance.
module tb_sync_bus_gen;

  localparam int unsigned NL = 5;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_s = 1'b1;
  always #5 clk = ~clk;

  sync_bus_gen_if #(.N_LAYERS(NL)) bus ();
  sync_bus_gen_if #(.N_LAYERS(1))  bus_s ();

  sync_bus_gen #(.N_LAYERS(NL)) dut (
    .clkm_48MHZ (clk),
    .RESET      (rst),
    .bus        (bus)
  );

  sync_bus_gen #(
    .H_START(0), .H_LAST(15), .HS_START(2), .HS_END(4), .VINC_H(10),
    .V_START(248), .V_LAST(255), .VBL_START(253), .VBL_END(250), .N_LAYERS(1)
  ) dut_s (
    .clkm_48MHZ (clk),
    .RESET      (rst_s),
    .bus        (bus_s)
  );

  typedef struct {
    logic [8:0] h;
    logic       hinv;
    logic       vinv;
    logic [7:0] sb_h;
    logic [7:0] sb_v;
    logic [7:0] ph;
    logic       hsync;
    logic       hbl;
  } vec_t;

  vec_t       vt [12];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         hs_cnt  = 0;
  int         vinc_cnt = 0;
  int         vinc_h  = 0;
  int         guard;
  logic [8:0] mdl_h;
  logic [8:0] mdl_v;
  logic [8:0] last_v;
  logic [2:0] dh_m [NL];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] dut_v();
    return {bus.VSYNC, bus.SB_V ^ {8{bus.VINV}}};
  endfunction

  function automatic logic [NL-1:0] snld_exp();
    logic [NL-1:0] r;
    for (int i = 0; i < int'(NL); i++) r[i] = (dh_m[i] != mdl_h[2:0]);
    return r;
  endfunction

  // PH after at least 8 contiguous pixel steps ending at h
  function automatic logic [7:0] ph_exp(input logic [8:0] h);
    logic [7:0] r;
    logic [2:0] lo;
    for (int k = 0; k < 8; k++) begin
      lo   = h[2:0] - 3'(k + 1);
      r[k] = !(lo == 3'd6 || lo == 3'd7);
    end
    return r;
  endfunction

  task automatic mdl_adv();
    if (mdl_h == 9'd368) mdl_v = (mdl_v == 9'd511) ? 9'd248 : mdl_v + 9'd1;
    mdl_h = (mdl_h == 9'd511) ? 9'd128 : mdl_h + 9'd1;
  endtask

  // One pixel step with CE_PIX on every 8th clock
  task automatic step_pix();
    bus.CE_PIX = 1'b1;
    clk1();
    bus.CE_PIX = 1'b0;
    mdl_adv();
    if (bus.HSYNC) hs_cnt++;
    if (dut_v() != last_v) begin
      vinc_cnt++;
      vinc_h = int'(bus.SB_HN);
      last_v = dut_v();
    end
    repeat (7) clk1();
  endtask

  // Short-frame instance: VPIX after edge n (line step at old HPIX=10, 16-pixel lines)
  function automatic logic s_vbl(input int n);
    int k;
    int v;
    if (n < 0) return 1'b1;
    k = (n >= 11) ? (n - 11) / 16 + 1 : 0;
    v = 248 + (k % 8);
    return (v >= 253) || (v < 250);
  endfunction

  initial begin
    vt[0]  = '{9'd128, 1'b0, 1'b0, 8'h80, 8'hF8, 8'h00, 1'b0, 1'b1};
    vt[1]  = '{9'd159, 1'b0, 1'b1, 8'h9F, 8'h07, 8'h7E, 1'b0, 1'b1};
    vt[2]  = '{9'd160, 1'b0, 1'b0, 8'hA0, 8'hF8, 8'hFC, 1'b1, 1'b1};
    vt[3]  = '{9'd192, 1'b0, 1'b0, 8'hC0, 8'hF8, 8'hFC, 1'b1, 1'b1};
    vt[4]  = '{9'd193, 1'b1, 1'b0, 8'h3E, 8'hF8, 8'hF9, 1'b0, 1'b1};
    vt[5]  = '{9'd255, 1'b1, 1'b0, 8'h00, 8'hF8, 8'h7E, 1'b0, 1'b1};
    vt[6]  = '{9'd256, 1'b0, 1'b0, 8'h00, 8'hF8, 8'hFC, 1'b0, 1'b0};
    vt[7]  = '{9'd368, 1'b0, 1'b0, 8'h70, 8'hF8, 8'hFC, 1'b0, 1'b0};
    vt[8]  = '{9'd369, 1'b0, 1'b0, 8'h71, 8'hF9, 8'hF9, 1'b0, 1'b0};
    vt[9]  = '{9'd421, 1'b1, 1'b1, 8'h5A, 8'h06, 8'h9F, 1'b0, 1'b0};
    vt[10] = '{9'd511, 1'b0, 1'b0, 8'hFF, 8'hF9, 8'h7E, 1'b0, 1'b0};
    vt[11] = '{9'd128, 1'b0, 1'b0, 8'h80, 8'hF9, 8'hFC, 1'b0, 1'b1};

    bus.CE_PIX = 1'b0;  bus.HINV = 1'b0;  bus.VINV = 1'b0;
    bus.Z80A_DATABUS = 8'h00;  bus.SPH = '0;
    bus_s.CE_PIX = 1'b1;  bus_s.HINV = 1'b0;  bus_s.VINV = 1'b0;
    bus_s.Z80A_DATABUS = 8'h00;  bus_s.SPH = '0;
    mdl_h = 9'd128;  mdl_v = 9'd248;  last_v = 9'd248;
    for (int i = 0; i < int'(NL); i++) dh_m[i] = 3'd0;

    // Reset state
    repeat (3) clk1();
    chk("rst_sb_hn",  bus.SB_HN, 9'd128);
    chk("rst_ph",     bus.PH, 8'h00);
    chk("rst_sb_v",   bus.SB_V, 8'hF8);
    chk("rst_vbl",    bus.VBL, 1'b1);
    chk("rst_blank",  bus.BLANK, 1'b1);
    chk("rst_hsync",  bus.HSYNC, 1'b0);
    chk("rst_vsync",  bus.VSYNC, 1'b0);
    chk("rst_irq",    bus.VBL_IRQ, 1'b0);
    chk("rst_fstart", bus.FRAME_START, 1'b0);
    chk("rst_snld",   bus.SNLD, 5'b00000);
    rst = 1'b0;
    clk1();

    // One full line, table-driven
    for (int i = 0; i < 12; i++) begin
      bus.HINV = vt[i].hinv;
      bus.VINV = vt[i].vinv;
      #1;
      guard = 0;
      while (bus.SB_HN !== vt[i].h && guard < 1000) begin
        step_pix();
        guard++;
      end
      chk($sformatf("vec%0d_reach", i), bus.SB_HN, vt[i].h);
      chk($sformatf("vec%0d_sb_h", i),  bus.SB_H,  vt[i].sb_h);
      chk($sformatf("vec%0d_sb_v", i),  bus.SB_V,  vt[i].sb_v);
      chk($sformatf("vec%0d_ph", i),    bus.PH,    vt[i].ph);
      chk($sformatf("vec%0d_hsync", i), bus.HSYNC, vt[i].hsync);
      chk($sformatf("vec%0d_hbl", i),   bus.HBL,   vt[i].hbl);
    end
    chk("hsync_steps", hs_cnt, 33);
    chk("vinc_per_line", vinc_cnt, 1);
    chk("vinc_at_h", vinc_h, 369);
    bus.HINV = 1'b0;
    bus.VINV = 1'b0;

    // Scroll write on layer 4 only; high data bits ignored
    bus.Z80A_DATABUS = 8'hFD;
    bus.SPH = 5'b10000;
    clk1();
    bus.SPH = '0;
    dh_m[4] = 3'd5;
    chk("snld_after_wr", bus.SNLD, snld_exp());
    for (int s = 0; s < 8; s++) begin
      step_pix();
      chk($sformatf("snld_step%0d", s), bus.SNLD, snld_exp());
    end

    // CE_PIX low for 100 clocks, scroll write still lands
    repeat (50) clk1();
    bus.Z80A_DATABUS = 8'h03;
    bus.SPH = 5'b00010;
    clk1();
    bus.SPH = '0;
    dh_m[1] = 3'd3;
    repeat (49) clk1();
    chk("hold_hpix", bus.SB_HN, mdl_h);
    chk("hold_vpix", dut_v(), mdl_v);
    chk("hold_ph",   bus.PH, ph_exp(mdl_h));
    chk("hold_vbl",  bus.VBL, 1'b1);
    chk("hold_snld", bus.SNLD, snld_exp());

    // Reset mid-line at HPIX=300 with SPH[0] held high
    guard = 0;
    while (mdl_h != 9'd300 && guard < 2000) begin
      step_pix();
      guard++;
    end
    chk("pre_rst_hpix", bus.SB_HN, 9'd300);
    bus.Z80A_DATABUS = 8'h01;
    bus.SPH = 5'b00001;
    #2 rst = 1'b1;
    #1;
    chk("midrst_hpix", bus.SB_HN, 9'd128);
    chk("midrst_ph",   bus.PH, 8'h00);
    mdl_h = 9'd128;
    mdl_v = 9'd248;
    last_v = 9'd248;
    for (int i = 0; i < int'(NL); i++) dh_m[i] = 3'd0;
    repeat (2) clk1();
    #2 rst = 1'b0;
    repeat (3) clk1();
    chk("sph_held_no_latch", bus.SNLD, snld_exp());
    step_pix();
    chk("first_ce_hpix", bus.SB_HN, 9'd129);
    chk("sph_held_step", bus.SNLD, snld_exp());
    bus.SPH = '0;
    clk1();
    bus.SPH = 5'b00001;
    clk1();
    bus.SPH = '0;
    dh_m[0] = 3'd1;
    chk("sph_relatch", bus.SNLD, snld_exp());

    // Run to VPIX=272 at full pixel rate: VBL clears there
    bus.CE_PIX = 1'b1;
    guard = 0;
    while (mdl_v != 9'd272 && guard < 20000) begin
      clk1();
      mdl_adv();
      if (mdl_v == 9'd271 && mdl_h == 9'd368) chk("vbl_before_clear", bus.VBL, 1'b1);
      guard++;
    end
    bus.CE_PIX = 1'b0;
    chk("v272_vpix",  dut_v(), 9'd272);
    chk("v272_vbl",   bus.VBL, 1'b0);
    chk("v272_blank", bus.BLANK, 1'b0);
    chk("v272_vsync", bus.VSYNC, 1'b1);
    bus.CE_PIX = 1'b1;
    guard = 0;
    while (mdl_h != 9'h1A5 && guard < 1000) begin
      clk1();
      mdl_adv();
      guard++;
    end
    bus.CE_PIX = 1'b0;
    bus.HINV = 1'b1;
    bus.VINV = 1'b1;
    #1;
    chk("flip_hpix", bus.SB_HN, 9'h1A5);
    chk("flip_sb_h", bus.SB_H, 8'h5A);
    chk("flip_sb_v", bus.SB_V, 8'hEF);

    // Short-frame instance: VBL set/clear, VBL_IRQ and FRAME_START over three frames
    chk("s_rst_vbl",    bus_s.VBL, 1'b1);
    chk("s_rst_fstart", bus_s.FRAME_START, 1'b0);
    chk("s_rst_irq",    bus_s.VBL_IRQ, 1'b0);
    rst_s = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      clk1();
      chk($sformatf("s_vbl_%0d", n), bus_s.VBL, s_vbl(n));
      chk($sformatf("s_irq_%0d", n), bus_s.VBL_IRQ, s_vbl(n - 1) && !s_vbl(n - 2));
      chk($sformatf("s_fstart_%0d", n), bus_s.FRAME_START,
          (n >= 124) && ((n - 124) % 128 == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
